// File: rtl/cla_topic_free_list_pool.sv
// Topic-value buffer free-pointer pool: FIFO-ordered storage plus a 2-entry prefetch for zero-latency head.
// Latency: release to head 3 cycles into an empty pool; no backpressure, bad or surplus releases are dropped with a flag.

`ifndef TOPIC_VALUE_DEPTH_NBITS
`define TOPIC_VALUE_DEPTH_NBITS 5
`endif

// Generic FIFO with combinational head read; pointers wrap at DEPTH so any depth works.
// Latency: write visible next cycle; caller must never write when full or read when empty.
module cla_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr,
  input  logic [W-1:0]  wdat,
  input  logic          rd,
  output logic [W-1:0]  rdat,
  output logic [CW-1:0] cnt
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= ptr_inc(wptr);
      if (rd) rptr <= ptr_inc(rptr);
      if (wr && !rd)      cnt <= cnt + 1'b1;
      else if (rd && !wr) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !clr) mem[wptr] <= wdat;
  end

  assign rdat = mem[rptr];
endmodule

module cla_topic_free_list_pool #(
  parameter int BPTR_NBITS = `TOPIC_VALUE_DEPTH_NBITS,
  parameter int NUM_BUFS   = 1 << BPTR_NBITS,
  parameter int BASE_PTR   = 0,
  parameter int LOW_WM     = 4,
  parameter int CNT_NBITS  = $clog2(NUM_BUFS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeb_init,
  input  logic                  rel_buf_valid,
  input  logic [BPTR_NBITS-1:0] rel_buf_ptr,
  input  logic                  free_buf_rd,
  output logic                  free_buf_valid,
  output logic [BPTR_NBITS-1:0] free_buf_ptr,
  output logic                  freeb_init_done,
  output logic [CNT_NBITS-1:0]  free_count,
  output logic                  low_wm,
  output logic                  err_overflow,
  output logic                  err_range,
  output logic                  err_underflow
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int OW = BPTR_NBITS + 2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [BPTR_NBITS-1:0] fill_idx;
  logic                  s1_vld;
  logic [BPTR_NBITS-1:0] s1_ptr;
  logic [OW-1:0]         s1_off;
  logic                  s1_live;
  logic                  s1_in_range;
  logic                  pool_full;
  logic                  rel_wr;
  logic                  fill_wr;
  logic                  st_wr;
  logic [BPTR_NBITS-1:0] st_wdat;
  logic                  st_rd;
  logic [BPTR_NBITS-1:0] st_rdat;
  logic [CNT_NBITS-1:0]  st_cnt;
  logic [1:0]            pf_cnt;
  logic                  pop;
  logic                  clr;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_FILL;
      S_FILL:  state_nxt = (fill_idx == BPTR_NBITS'(NUM_BUFS - 1)) ? S_DONE : S_FILL;
      S_DONE:  state_nxt = freeb_init ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      fill_idx        <= '0;
      freeb_init_done <= 1'b0;
    end else begin
      state           <= state_nxt;
      freeb_init_done <= (state_nxt == S_DONE);
      if (state == S_CLEAR)     fill_idx <= '0;
      else if (state == S_FILL) fill_idx <= fill_idx + 1'b1;
    end
  end

  // Release stage: only captured in DONE, and discarded if the FSM left DONE meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_ptr <= '0;
    end else begin
      s1_vld <= rel_buf_valid && (state == S_DONE);
      s1_ptr <= rel_buf_ptr;
    end
  end

  // A negative offset sets the top bit, so one subtract covers both pool bounds.
  assign s1_off      = {2'b00, s1_ptr} - OW'(BASE_PTR);
  assign s1_in_range = !s1_off[OW-1] && (s1_off[OW-2:0] < (OW-1)'(NUM_BUFS));
  assign s1_live     = s1_vld && (state == S_DONE);
  assign pool_full   = (free_count == CNT_NBITS'(NUM_BUFS));
  assign err_range    = s1_live && !s1_in_range;
  assign err_overflow = s1_live && s1_in_range && pool_full;
  assign rel_wr       = s1_live && s1_in_range && !pool_full;

  assign fill_wr = (state == S_FILL);
  assign st_wr   = fill_wr || rel_wr;
  assign st_wdat = fill_wr ? (BPTR_NBITS'(BASE_PTR) + fill_idx) : s1_ptr;
  assign clr     = (state == S_CLEAR);

  assign free_buf_valid = freeb_init_done && (pf_cnt != 2'd0);
  assign pop            = free_buf_rd && free_buf_valid;
  assign st_rd          = (st_cnt != '0) && (state != S_FILL) && (pf_cnt != 2'd2);

  cla_fifo #(.W(BPTR_NBITS), .DEPTH(NUM_BUFS), .CW(CNT_NBITS)) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .wr    (st_wr),
    .wdat  (st_wdat),
    .rd    (st_rd),
    .rdat  (st_rdat),
    .cnt   (st_cnt)
  );

  cla_fifo #(.W(BPTR_NBITS), .DEPTH(2), .CW(2)) u_prefetch (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .wr    (st_rd),
    .wdat  (st_rdat),
    .rd    (pop),
    .rdat  (free_buf_ptr),
    .cnt   (pf_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_count    <= '0;
      low_wm        <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      low_wm        <= (free_count <= CNT_NBITS'(LOW_WM));
      err_underflow <= free_buf_rd && !free_buf_valid;
      if (clr)                free_count <= '0;
      else if (st_wr && !pop) free_count <= free_count + 1'b1;
      else if (pop && !st_wr) free_count <= free_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_cla_topic_free_list_pool.sv
// Directed bench for the free-pointer pool; a queue-based model is checked every cycle alongside literal expectations.
module tb_cla_topic_free_list_pool;
  localparam int PW = 5;
  localparam int NB = 12;
  localparam int BP = 16;
  localparam int LW = 4;
  localparam int CW = $clog2(NB + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          freeb_init = 1'b0;
  logic          rel_buf_valid = 1'b0;
  logic [PW-1:0] rel_buf_ptr = '0;
  logic          free_buf_rd = 1'b0;
  logic          free_buf_valid;
  logic [PW-1:0] free_buf_ptr;
  logic          freeb_init_done;
  logic [CW-1:0] free_count;
  logic          low_wm;
  logic          err_overflow;
  logic          err_range;
  logic          err_underflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_topic_free_list_pool #(
    .BPTR_NBITS(PW), .NUM_BUFS(NB), .BASE_PTR(BP), .LOW_WM(LW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .freeb_init      (freeb_init),
    .rel_buf_valid   (rel_buf_valid),
    .rel_buf_ptr     (rel_buf_ptr),
    .free_buf_rd     (free_buf_rd),
    .free_buf_valid  (free_buf_valid),
    .free_buf_ptr    (free_buf_ptr),
    .freeb_init_done (freeb_init_done),
    .free_count      (free_count),
    .low_wm          (low_wm),
    .err_overflow    (err_overflow),
    .err_range       (err_range),
    .err_underflow   (err_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of pointers, each tagged with the first cycle it may be presented at the head.
  typedef struct { int ptr; int avail; } ent_t;
  ent_t q[$];
  int   m_cyc, m_t, m_cnt, m_s1_ptr;
  bit   m_low, m_uf, m_s1;

  function automatic bit m_done();
    return m_t >= NB + 2;
  endfunction
  function automatic bit m_valid();
    return m_done() && (q.size() > 0) && (q[0].avail <= m_cyc);
  endfunction
  function automatic bit m_bad();
    return (m_s1_ptr < BP) || (m_s1_ptr >= BP + NB);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cyc = 0; m_t = 0; m_cnt = 0; m_s1_ptr = 0;
      m_low = 1'b0; m_uf = 1'b0; m_s1 = 1'b0;
    end else begin
      bit done, vld, pop, acc;
      done = m_done();
      vld  = m_valid();
      pop  = free_buf_rd && vld;
      acc  = m_s1 && done && !m_bad() && (m_cnt != NB);
      m_low = (m_cnt <= LW);
      m_uf  = free_buf_rd && !vld;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{ptr: m_s1_ptr, avail: m_cyc + 2});
      if (done)          m_cnt = m_cnt + int'(acc) - int'(pop);
      else if (m_t == 1) m_cnt = 0;
      else if (m_t >= 2) m_cnt = m_cnt + 1;
      m_s1     = rel_buf_valid && done;
      m_s1_ptr = int'(rel_buf_ptr);
      if (done && freeb_init) begin
        m_t = 0;
        q.delete();
      end else if (!done) begin
        m_t++;
        if (m_t == NB + 2)
          for (int i = 0; i < NB; i++) q.push_back('{ptr: BP + i, avail: m_cyc + 2});
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    chk("valid", free_buf_valid, m_valid());
    if (m_valid()) chk("ptr", free_buf_ptr, q[0].ptr);
    chk("init_done", freeb_init_done, m_done());
    chk("free_count", free_count, m_cnt);
    chk("low_wm", low_wm, m_low);
    chk("err_range", err_range, m_s1 && m_done() && m_bad());
    chk("err_overflow", err_overflow, m_s1 && m_done() && !m_bad() && (m_cnt == NB));
    chk("err_underflow", err_underflow, m_uf);
  end

  task automatic wait_valid();
    int k = 0;
    while (!free_buf_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wait_valid", free_buf_valid, 1);
  endtask

  task automatic pop_seq(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      free_buf_rd = 1'b0;
      wait_valid();
      chk("pop_ptr", free_buf_ptr, first + i);
      free_buf_rd = 1'b1;
      @(negedge clk);
    end
    free_buf_rd = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_valid", free_buf_valid, 0);
    chk("rst_done", freeb_init_done, 0);
    chk("rst_count", free_count, 0);
    chk("rst_low_wm", low_wm, 0);
    rst_n = 1'b1;

    // Init timing and drain in FIFO order.
    tick(13);
    chk("done_at_13", freeb_init_done, 0);
    tick(1);
    chk("done_at_14", freeb_init_done, 1);
    chk("count_at_14", free_count, 12);
    tick(1);
    chk("valid_at_15", free_buf_valid, 1);
    pop_seq(12, 16);
    chk("drained_valid", free_buf_valid, 0);
    chk("drained_low_wm", low_wm, 1);

    // Release into an empty pool: head after 3 cycles.
    rel_buf_valid = 1'b1; rel_buf_ptr = 5'd21;
    tick(1);
    rel_buf_valid = 1'b0;
    tick(1);
    chk("rel_lat_t2", free_buf_valid, 0);
    tick(1);
    chk("rel_lat_t3", free_buf_valid, 1);
    chk("rel_ptr", free_buf_ptr, 21);
    chk("rel_count", free_count, 1);
    free_buf_rd = 1'b1;
    tick(2);
    free_buf_rd = 1'b0;
    chk("underflow_pulse", err_underflow, 1);
    chk("underflow_valid", free_buf_valid, 0);

    // Out-of-range releases at both sides of the pool.
    rel_buf_valid = 1'b1; rel_buf_ptr = 5'd15;
    tick(1);
    rel_buf_ptr = 5'd28;
    chk("range_lo", err_range, 1);
    tick(1);
    rel_buf_valid = 1'b0;
    chk("range_hi", err_range, 1);
    tick(1);
    chk("range_clear", err_range, 0);
    chk("range_count", free_count, 0);

    // Re-init with releases in flight.
    rel_buf_valid = 1'b1; rel_buf_ptr = 5'd16;
    tick(1);
    rel_buf_ptr = 5'd17; freeb_init = 1'b1;
    tick(1);
    freeb_init = 1'b0; rel_buf_ptr = 5'd18;
    chk("reinit_done_drop", freeb_init_done, 0);
    tick(1);
    rel_buf_valid = 1'b0;
    tick(12);
    chk("reinit_done_13", freeb_init_done, 0);
    tick(1);
    chk("reinit_done_14", freeb_init_done, 1);
    chk("reinit_count", free_count, 12);

    // Release into a full pool.
    rel_buf_valid = 1'b1; rel_buf_ptr = 5'd20;
    tick(1);
    rel_buf_valid = 1'b0;
    chk("overflow_pulse", err_overflow, 1);
    tick(1);
    chk("overflow_clear", err_overflow, 0);
    chk("overflow_count", free_count, 12);
    pop_seq(12, 16);
    tick(1);
    chk("no_dup_valid", free_buf_valid, 0);

    // Seed six pointers, then pop and release every cycle.
    for (int i = 0; i < 6; i++) begin
      rel_buf_valid = 1'b1; rel_buf_ptr = PW'(16 + i);
      tick(1);
    end
    rel_buf_valid = 1'b0;
    tick(3);
    chk("stream_seed", free_count, 6);
    for (int i = 0; i <= 50; i++) begin
      rel_buf_valid = (i < 50);
      rel_buf_ptr   = PW'(16 + (i * 5) % 12);
      free_buf_rd   = (i > 0);
      tick(1);
      chk("stream_count", free_count, 6);
    end
    rel_buf_valid = 1'b0;
    free_buf_rd   = 1'b0;
    tick(2);
    chk("stream_end_count", free_count, 6);

    // Asynchronous reset mid-cycle, then init reruns.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", freeb_init_done, 0);
    chk("arst_valid", free_buf_valid, 0);
    chk("arst_count", free_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int k = 0;
      while (!freeb_init_done && k < 30) begin
        tick(1);
        k++;
      end
      chk("arst_reinit_cycles", k, 14);
    end
    chk("arst_reinit_count", free_count, 12);
    tick(2);
    chk("arst_head", free_buf_ptr, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cla_topic_free_list_pool.md
Name: cla_topic_free_list_pool

Overview:
- Parametrised free-pointer manager for classifier topic-value buffers; next generation of the topic free list.
- Adds non-power-of-two pool size and base offset, live free count, low-watermark flag, and release/allocate error detection with drop.
- Sits between the topic value store (releases) and topic allocation logic (consumers).
- Pointer order is FIFO: storage RAM plus a 2-entry prefetch stage, so head pointer is presented with zero read latency.

Parameters:
- BPTR_NBITS, `TOPIC_VALUE_DEPTH_NBITS, width of a buffer pointer.
- NUM_BUFS, 1<<BPTR_NBITS, pointers managed; any value 2..(1<<BPTR_NBITS)-BASE_PTR.
- BASE_PTR, 0, first pointer value; pool is BASE_PTR..BASE_PTR+NUM_BUFS-1.
- LOW_WM, 4, low-watermark threshold.
- CNT_NBITS, $clog2(NUM_BUFS+1), free-count width.

Ports:
- clk  in  1  clock.
- `RESET_SIG  in  1  asynchronous, active-low reset.
- freeb_init  in  1  re-initialise request pulse.
- rel_buf_valid  in  1  release strobe.
- rel_buf_ptr  in  BPTR_NBITS  released pointer.
- free_buf_rd  in  1  pop head pointer.
- free_buf_valid  out  1  head pointer valid (init done and prefetch non-empty).
- free_buf_ptr  out  BPTR_NBITS  head pointer.
- freeb_init_done  out  1  pool initialised.
- free_count  out  CNT_NBITS  pointers currently held.
- low_wm  out  1  registered (free_count <= LOW_WM).
- err_overflow  out  1  1-cycle pulse: release into a full pool, dropped.
- err_range  out  1  1-cycle pulse: out-of-range release, dropped.
- err_underflow  out  1  1-cycle pulse: free_buf_rd while !free_buf_valid.

Behaviour:
- Reset: all outputs 0; free_buf_ptr don't-care. Init FSM enters IDLE and storage/prefetch pointers are cleared.
- Init FSM:
  - IDLE -> CLEAR (1 cycle).
  - CLEAR (1 cycle) holds storage and prefetch FIFOs in reset and clears free_count -> FILL.
  - FILL writes BASE_PTR+i for i = 0..NUM_BUFS-1, one per cycle, and free_count increments per write. After the last write -> DONE.
  - freeb_init_done registers (next state == DONE), so it rises NUM_BUFS+2 cycles after reset release.
- freeb_init is honoured only in DONE and returns the FSM to IDLE. All held and in-flight pointers are discarded, and freeb_init_done drops the next cycle. freeb_init in other states is ignored.
- Release path:
  - rel_buf_valid/rel_buf_ptr are registered (stage S1).
  - At S1, the entry is dropped with err_overflow if free_count == NUM_BUFS.
  - At S1, the entry is dropped with err_range if the pointer is outside the pool. err_range takes priority, and only one error flag asserts.
  - Otherwise the pointer is written to storage.
  - Releases arriving while not in DONE are silently dropped.
- Release-to-allocate latency into an empty pool: rel_buf_valid at cycle T gives free_buf_valid at T+3, with free_buf_ptr equal to the released pointer.
- Allocate:
  - free_buf_rd with free_buf_valid pops the head, and the next pointer appears the following cycle if available.
  - Back-to-back pops every cycle are sustained while storage is non-empty.
  - free_buf_rd without free_buf_valid is ignored and pulses err_underflow.
- Prefetch refill:
  - Storage is read when storage is non-empty and the FSM is not in FILL.
  - Storage is not read when the prefetch is full, or when it is full-minus-one with a refill already in flight.
  - The prefetch never overflows.
- free_count:
  - +1 on each accepted storage write; -1 on each accepted pop; unchanged on a simultaneous write and pop.
  - Never exceeds NUM_BUFS and never wraps below 0.
  - low_wm is updated one cycle after free_count.
- Reset assertion mid-operation asynchronously returns the block to the reset state. Init then reruns after reset deassertion.

Test Plan:
- Init, NUM_BUFS=12, BASE_PTR=16 -> freeb_init_done at cycle 14; free_count=12; 12 pops return 16..27 in order; free_buf_valid=0 afterwards; low_wm asserts when free_count reaches 4.
- Drain pool, release 21 at T -> free_buf_valid at T+3 with free_buf_ptr=21; free_count=1.
- Full pool, release 20 -> err_overflow pulse at T+1; free_count stays 12; the pop sequence contains no duplicate 20.
- Release 15 and release 28 (out of range) -> two err_range pulses; free_count unchanged. Pop with pool empty -> err_underflow pulse; outputs otherwise unchanged.
- Simultaneous pop and release every cycle for 50 cycles with free_count=6 -> free_count stays 6; FIFO order preserved.
- freeb_init mid-traffic in DONE -> freeb_init_done drops next cycle; in-flight releases are dropped; re-init completes after 14 cycles; free_count=12 and pops return 16..27.
